adaptive_threshold: RTL and testbench
=====================================

Name: adaptive_threshold

Overview:
- Streaming stage directly downstream of the 2-D convolution block.
- Consumes signed convolution results, one per valid/ready beat, and emits a 1-bit pixel: |x| > threshold.
- The threshold adapts per frame: the mean |x| of frame N becomes the threshold applied to frame N+1.
- Feeds binary downstream stages, e.g. blob/centroid, with one cycle of latency.

Parameters:
- LineWidthPx, 158: pixels per line of the incoming stream (convolution output width).
- LineCountPx, 118: lines per frame of the incoming stream.
- WidthIn, 32: signed input sample width.
- InitThreshold, 0: threshold used after reset until the first frame completes; unsigned, WidthIn-1 bits.
- RecipShift, 16: fixed-point shift for the mean reciprocal.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input sample valid.
- ready_o  output  1  block can accept input.
- data_i  input  WidthIn  signed convolution result.
- valid_o  output  1  output pixel valid.
- ready_i  input  1  downstream accepts output.
- data_o  output  1  binarized pixel.
- threshold_o  output  WidthIn-1  threshold currently applied.
- frame_done_o  output  1  one-cycle pulse on acceptance of the last pixel of a frame.

Behaviour:
- Reset: asynchronous, active-low; all state clears immediately on assertion of rst_ni.
  - valid_o=0, data_o=0, frame_done_o=0, threshold_o=InitThreshold.
  - Counters, accumulator, and state return to WARMUP.
- Handshake: single elastic register.
  - ready_o = ~valid_r | ready_i.
  - in_fire = valid_i & ready_o.
  - When ready_o is high: valid_r <= in_fire and data_r <= (abs(data_i) > threshold_r).
  - Latency is exactly 1 cycle; full throughput of one beat per cycle under continuous ready_i.
  - While valid_o is high and ready_i is low, data_o holds stable.
- abs: |data_i| is saturated. The most negative input maps to 2^(WidthIn-1)-1; other negative values negate exactly. Result width is WidthIn-1, unsigned.
- Position counters x (0..LineWidthPx-1) and y (0..LineCountPx-1):
  - Advance only on in_fire.
  - x wraps to 0 at the last column and y increments; y wraps to 0 after the last row.
- Accumulator: acc, width WidthIn-1+$clog2(LineWidthPx*LineCountPx).
  - On in_fire: acc <= acc + abs(data_i). The accumulator cannot overflow.
- Frame end: on in_fire at x=last and y=last.
  - mean = ((acc + abs(data_i)) * Recip) >> RecipShift, where Recip = ceil(2^RecipShift / Area) is a package constant function.
  - mean is saturated to WidthIn-1 bits.
  - threshold_r <= mean; acc <= 0; frame_done_o pulses in the following cycle, aligned with valid_o of that pixel.
  - The last pixel itself is compared against the old threshold.
- State machine:
  - WARMUP -> RUN on the first frame end; RUN stays in RUN.
  - In WARMUP the threshold is InitThreshold. The state is observable only through threshold_o, and determines the smoothing rule under the optional feature.
- Reset mid-frame: the partial accumulator is discarded and counting restarts at (0,0).
- Back-pressure: valid_i with ready_o=0 leaves counters and accumulator unchanged.

Optional Feature:
- Macro: ADAPTIVE_THRESHOLD_SMOOTH_EN.
- Defined: in RUN, threshold_r <= (threshold_r + mean + 1) >> 1, i.e. a rounded IIR average. The first frame end (WARMUP -> RUN) loads mean directly.
- Undefined: threshold_r <= mean at every frame end.
- No port changes in either case.

Decomposition:
- adaptive_threshold_pkg holds:
  - the state enum type (WARMUP, RUN);
  - the function recip_f(area, shift) computing ceil(2^shift/area);
  - the function acc_width_f.
- Sub-module frame_mean_acc holds the abs, the accumulator, and the multiply-shift.
  - Inputs: sample, fire, last.
  - Outputs: mean and a mean_valid pulse.
- Top level owns the handshake register, the counters, the FSM, and threshold_r.

Test Plan:
- Params LineWidthPx=4, LineCountPx=2, InitThreshold=0, RecipShift=16 (Recip=8192).
  - Feed 1..8 -> all 8 outputs are 1.
  - frame_done_o pulses with the 8th output.
  - threshold_o becomes 4 (36*8192>>16).
- Second frame of samples 3,4,5,6,-3,-4,-5,-6 -> outputs 0,0,1,1,0,0,1,1.
  - threshold_o becomes 4 without smoothing.
  - With smoothing: (4+4+1)>>1 = 4.
- data_i = -2^31 -> abs saturates to 2^31-1 and the output is 1; acc increases by 2^31-1.
- Hold ready_i=0 for 5 cycles mid-frame with valid_i=1:
  - data_o and valid_o stay stable;
  - x/y counters do not advance;
  - after release, the output sequence is unchanged and there are no drops or duplicates.
- Deassert rst_ni asynchronously after 3 pixels of a frame, then feed 8 pixels of value 2:
  - threshold_o reads 0 during reset;
  - frame_done_o pulses on the 8th new pixel;
  - threshold_o becomes 2.
- Random valid_i/ready_i over 10 frames, checked against a reference model: pixel order, per-frame threshold, and frame_done_o count = 10.

Source files
------------

// File: rtl/adaptive_threshold_pkg.sv
// Shared types and constant functions for the adaptive threshold stage.
package adaptive_threshold_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  // Accumulator width: one full frame of saturated |x| values cannot overflow it.
  function automatic int unsigned acc_width_f(input int unsigned width_in,
                                              input int unsigned area);
    return width_in - 1 + $clog2(area);
  endfunction

  // ceil(2^shift / area), the fixed-point reciprocal used to form the mean.
  function automatic longint unsigned recip_f(input longint unsigned area,
                                              input int unsigned shift);
    return ((64'd1 << shift) + area - 64'd1) / area;
  endfunction

endpackage

// File: rtl/adaptive_threshold_frame_mean_acc.sv
// Saturating |x|, per-frame accumulator and reciprocal multiply-shift mean.
// The mean is combinational so the owner can latch it on the frame-ending beat.
module adaptive_threshold_frame_mean_acc
  import adaptive_threshold_pkg::*;
#(
  parameter int unsigned WidthIn    = 32,
  parameter int unsigned Area       = 18644,
  parameter int unsigned RecipShift = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WidthIn-1:0] sample_i,
  input  logic               fire_i,
  input  logic               last_i,
  output logic [WidthIn-2:0] abs_c,
  output logic [WidthIn-2:0] mean_c,
  output logic               mean_valid_c
);

  localparam int unsigned AbsW   = WidthIn - 1;
  localparam int unsigned AccW   = acc_width_f(WidthIn, Area);
  localparam int unsigned RecipW = RecipShift + 1;
  localparam int unsigned ProdW  = AccW + RecipW;
  localparam int unsigned QuotW  = ProdW - RecipShift;
  localparam logic [RecipW-1:0] Recip   = RecipW'(recip_f(64'(Area), RecipShift));
  localparam logic [QuotW-1:0]  MeanMax = QuotW'({AbsW{1'b1}});

  logic [AccW-1:0]  acc_q;
  logic [AccW-1:0]  acc_sum;
  logic [ProdW-1:0] prod;
  logic [QuotW-1:0] quot;

  // Most negative input saturates instead of wrapping back to itself.
  always_comb begin
    abs_c = sample_i[WidthIn-2:0];
    if (sample_i[WidthIn-1]) begin
      if (sample_i[WidthIn-2:0] == '0) begin
        abs_c = '1;
      end else begin
        abs_c = AbsW'(-sample_i);
      end
    end
  end

  always_comb begin
    acc_sum      = acc_q + AccW'(abs_c);
    prod         = ProdW'(acc_sum) * ProdW'(Recip);
    quot         = QuotW'(prod >> RecipShift);
    mean_c       = (quot > MeanMax) ? '1 : quot[AbsW-1:0];
    mean_valid_c = fire_i & last_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (fire_i) begin
      acc_q <= last_i ? '0 : acc_sum;
    end
  end

endmodule

// File: rtl/adaptive_threshold.sv
// Binarizes |x| against a threshold equal to the previous frame's mean |x|.
// Define ADAPTIVE_THRESHOLD_SMOOTH_EN for a rounded IIR average of successive means.
module adaptive_threshold
  import adaptive_threshold_pkg::*;
#(
  parameter int unsigned       LineWidthPx   = 158,
  parameter int unsigned       LineCountPx   = 118,
  parameter int unsigned       WidthIn       = 32,
  parameter logic [WidthIn-2:0] InitThreshold = '0,
  parameter int unsigned       RecipShift    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WidthIn-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               data_o,
  output logic [WidthIn-2:0] threshold_o,
  output logic               frame_done_o
);

  localparam int unsigned XW   = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
  localparam int unsigned YW   = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
  localparam int unsigned Area = LineWidthPx * LineCountPx;

  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic               valid_q;
  logic               data_q;
  logic               frame_done_q;
  logic [WidthIn-2:0] threshold_q;
  logic [WidthIn-2:0] run_threshold;
  logic [WidthIn-2:0] abs_val;
  logic [WidthIn-2:0] mean;
  logic               mean_valid;
  logic               in_fire;
  logic               x_last;
  logic               y_last;
  logic               frame_last;
  state_e             state_q;

  assign ready_o    = ~valid_q | ready_i;
  assign in_fire    = valid_i & ready_o;
  assign x_last     = (x_q == XW'(LineWidthPx - 1));
  assign y_last     = (y_q == YW'(LineCountPx - 1));
  assign frame_last = x_last & y_last;

  adaptive_threshold_frame_mean_acc #(
    .WidthIn    (WidthIn),
    .Area       (Area),
    .RecipShift (RecipShift)
  ) u_mean (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .sample_i     (data_i),
    .fire_i       (in_fire),
    .last_i       (frame_last),
    .abs_c        (abs_val),
    .mean_c       (mean),
    .mean_valid_c (mean_valid)
  );

`ifdef ADAPTIVE_THRESHOLD_SMOOTH_EN
  logic [WidthIn-1:0] smooth_sum;
  assign smooth_sum    = {1'b0, threshold_q} + {1'b0, mean} + WidthIn'(1);
  assign run_threshold = (WidthIn-1)'(smooth_sum >> 1);
`else
  assign run_threshold = mean;
`endif

  // Raster position of the next accepted sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_fire) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Single elastic output register; frame_done travels with its pixel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      data_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (ready_o) begin
      valid_q      <= in_fire;
      data_q       <= (abs_val > threshold_q);
      frame_done_q <= in_fire & frame_last;
    end
  end

  // The first frame end always loads the raw mean and leaves WARMUP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WARMUP;
      threshold_q <= InitThreshold;
    end else if (mean_valid) begin
      if (state_q == WARMUP) begin
        state_q     <= RUN;
        threshold_q <= mean;
      end else begin
        threshold_q <= run_threshold;
      end
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign frame_done_o = frame_done_q;
  assign threshold_o  = threshold_q;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Scoreboard bench for adaptive_threshold on a 4x2 frame.
module tb_adaptive_threshold;

  localparam int unsigned          W      = 4;
  localparam int unsigned          H      = 2;
  localparam int unsigned          AREA   = W * H;
  localparam int unsigned          SHIFT  = 16;
  localparam longint unsigned      ABSMAX = 64'h7FFF_FFFF;
  localparam longint unsigned      RECIP  = ((64'd1 << SHIFT) + AREA - 1) / AREA;

  typedef struct {
    logic            px;
    logic            fd;
    longint unsigned th;
  } exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic        data_o;
  logic [30:0] threshold_o;
  logic        frame_done_o;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  int stall_cnt = 0;
  int hold_cnt = 0;
  bit rand_ready = 1'b0;

  exp_t sb_q[$];

  longint unsigned m_th;
  longint unsigned m_sum;
  int              m_cnt;
  bit              m_run;

  adaptive_threshold #(
    .LineWidthPx   (W),
    .LineCountPx   (H),
    .WidthIn       (32),
    .InitThreshold (31'd0),
    .RecipShift    (SHIFT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .threshold_o  (threshold_o),
    .frame_done_o (frame_done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_th  = 0;
    m_sum = 0;
    m_cnt = 0;
    m_run = 1'b0;
    sb_q.delete();
  endtask

  // Reference: mean of |x| per frame, applied to the following frame.
  task automatic model_accept(input logic [31:0] d);
    longint          v;
    longint unsigned a;
    longint unsigned mean;
    exp_t            e;
    v = longint'($signed(d));
    a = (v < 0) ? longint'(-v) : v;
    if (a > ABSMAX) a = ABSMAX;
    e.px  = (a > m_th);
    m_sum = m_sum + a;
    m_cnt = m_cnt + 1;
    e.fd  = (m_cnt == AREA);
    if (e.fd) begin
      mean = (m_sum * RECIP) >> SHIFT;
      if (mean > ABSMAX) mean = ABSMAX;
`ifdef ADAPTIVE_THRESHOLD_SMOOTH_EN
      m_th = m_run ? (m_th + mean + 1) / 2 : mean;
`else
      m_th = mean;
`endif
      m_run = 1'b1;
      m_sum = 0;
      m_cnt = 0;
    end
    e.th = m_th;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [31:0] d, input int idle);
    int budget;
    repeat (idle) begin
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b1;
    data_i  = d;
    budget  = 0;
    forever begin
      @(negedge clk_i);
      if (ready_o) begin
        model_accept(d);
        @(posedge clk_i);
        #1;
        break;
      end
      budget++;
      if (budget > 200) begin
        chk("send_timeout", 1, 0);
        @(posedge clk_i);
        #1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(posedge clk_i);
      n++;
    end
    chk("drain_empty", sb_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  // Downstream readiness: forced hold, random, or always ready.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (hold_cnt > 0) begin
        ready_i  = 1'b0;
        hold_cnt = hold_cnt - 1;
      end else if (rand_ready) begin
        ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        ready_i = 1'b1;
      end
    end
  end

  // Monitor: pop and compare on every output handshake; check stall stability.
  bit   stall_prev = 1'b0;
  logic prev_d;
  logic prev_fd;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        stall_cnt++;
        chk("stall_valid", valid_o, 1);
        chk("stall_data", data_o, prev_d);
        chk("stall_fd", frame_done_o, prev_fd);
      end
      if (!valid_o) chk("fd_without_valid", frame_done_o, 0);
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("pixel", data_o, e.px);
          chk("frame_done", frame_done_o, e.fd);
          chk("threshold", threshold_o, e.th);
        end
        if (frame_done_o) fd_count++;
      end
      stall_prev = valid_o && !ready_i;
      prev_d     = data_o;
      prev_fd    = frame_done_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r;
    logic [31:0] d;
    logic [31:0] f2 [8];
    f2 = '{32'd3, 32'd4, 32'd5, 32'd6, -32'sd3, -32'sd4, -32'sd5, -32'sd6};

    rst_ni  = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    model_reset();
    #22;
    chk("rst_threshold", threshold_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_fd", frame_done_o, 0);
    chk("rst_ready", ready_o, 1);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Frame 1: 1..8 against the initial zero threshold.
    for (int i = 1; i <= 8; i++) send(32'(i), 0);
    drain();
    chk("thr_after_f1", threshold_o, 4);

    // Frame 2: mixed signs around threshold 4.
    for (int i = 0; i < 8; i++) send(f2[i], 0);
    drain();
    chk("thr_after_f2", threshold_o, 4);

    // Frame 3: most negative input and a 5-cycle downstream hold.
    send(32'd5, 0);
    send(32'h8000_0000, 0);
    s0 = stall_cnt;
    hold_cnt = 5;
    send(32'd7, 0);
    send(32'd1, 0);
    send(32'd2, 0);
    send(32'd3, 0);
    send(32'd4, 0);
    send(32'd5, 0);
    drain();
    chk("hold_stalls_seen", (stall_cnt - s0 >= 4) ? 1 : 0, 1);
    chk("thr_after_f3", threshold_o, m_th);

    // Frame 4: reset mid-frame after three pixels.
    for (int i = 0; i < 3; i++) send(32'd9, 0);
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("midrst_threshold", threshold_o, 0);
    chk("midrst_valid", valid_o, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #4;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) send(32'd2, 0);
    drain();
    chk("thr_after_rst_frame", threshold_o, 2);

    // Random traffic over ten frames.
    fd_count   = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      for (int p = 0; p < 8; p++) begin
        if ($urandom_range(0, 15) == 0) begin
          d = $urandom;
        end else begin
          r = int'($urandom_range(0, 400)) - 200;
          d = 32'(r);
        end
        send(d, int'($urandom_range(0, 2)));
      end
    end
    drain();
    rand_ready = 1'b0;
    chk("random_frame_count", fd_count, 10);
    chk("random_final_thr", threshold_o, m_th);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
